// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Hazard controller for a 5-stage ARM pipeline. Keeps a shadow
//             scoreboard of the instructions in ID/EX, EX/MEM and MEM/WB and
//             from it drives the EX operand forwarding selects, the load-use
//             stall and the taken-branch flush.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             id_*                fields of the instruction currently in ID
//             ex_br_taken         branch in EX resolved taken
//             fwd_a, fwd_b        00 regfile, 01 EX/MEM, 10 MEM/WB
//             pc_stall, if_id_stall, if_id_flush, id_ex_bubble
//             state               00 RUN, 01 LU_STALL, 10 FLUSH (informational)
//             stall_cnt, flush_cnt  (only with HAZARD_PERF_CNT_EN defined)
//  Config   : HAZARD_PERF_CNT_EN adds 32-bit stall/flush event counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rb,
    input  logic       id_use_a,
    input  logic       id_use_b,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       ex_br_taken,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [4:0] c_XZR         = 5'd31;
    localparam logic [1:0] c_ST_RUN      = 2'b00;
    localparam logic [1:0] c_ST_LU_STALL = 2'b01;
    localparam logic [1:0] c_ST_FLUSH    = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rb;
        logic       use_a;
        logic       use_b;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    slot_t      r_ex, r_mem, r_wb;
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_lu;
    logic       w_flush;

    // True when slot s will write register r; XZR writes are discarded.
    function automatic logic f_writes(input slot_t s, input logic [4:0] r);
        return s.valid & s.reg_write & (s.rd != c_XZR) & (s.rd == r);
    endfunction

    assign w_flush = ex_br_taken;
    assign w_lu    = id_valid & r_ex.mem_read &
                     ((id_use_a & f_writes(r_ex, id_rn)) |
                      (id_use_b & f_writes(r_ex, id_rb)));

    // Scoreboard shift; a bubble enters EX as an all-zero (invalid) slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (id_ex_bubble) begin
                r_ex <= '0;
            end else begin
                r_ex <= '{valid: id_valid, rd: id_rd, rn: id_rn, rb: id_rb,
                          use_a: id_use_a, use_b: id_use_b,
                          reg_write: id_reg_write, mem_read: id_mem_read};
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. Every event re-enters from any state; flush beats stall.
    always_comb begin
        w_state_nxt = c_ST_RUN;
        if (w_flush) begin
            w_state_nxt = c_ST_FLUSH;
        end else if (w_lu) begin
            w_state_nxt = c_ST_LU_STALL;
        end
    end

    // FSM: outputs. Controls are combinational from inputs and scoreboard;
    // reset forces them all low. On a flush the ID instruction is wrong-path,
    // so a coincident load-use match must not stall.
    always_comb begin
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst) begin
            if (r_ex.use_a && f_writes(r_mem, r_ex.rn)) begin
                fwd_a = 2'b01;
            end else if (r_ex.use_a && f_writes(r_wb, r_ex.rn)) begin
                fwd_a = 2'b10;
            end
            if (r_ex.use_b && f_writes(r_mem, r_ex.rb)) begin
                fwd_b = 2'b01;
            end else if (r_ex.use_b && f_writes(r_wb, r_ex.rb)) begin
                fwd_b = 2'b10;
            end
            if (w_flush) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (w_lu) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    assign state = r_state;

    // Fields carried for scoreboard completeness but never consulted downstream.
    logic w_unused_fields;
    assign w_unused_fields = ^{r_mem.rn, r_mem.rb, r_mem.use_a, r_mem.use_b,
                               r_mem.mem_read, r_wb.rn, r_wb.rb, r_wb.use_a,
                               r_wb.use_b, r_wb.mem_read};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (if_id_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage ARM datapath. Keeps a shadow scoreboard of the destination register, RegWrite and memRead for the instructions in the ID/EX, EX/MEM and MEM/WB slots. From that scoreboard it drives the forwarding mux selects for the EX-stage ALU operands, stalls on load-use hazards, and flushes the front of the pipe on taken branches. It sits beside the pipeline registers; its outputs drive the PC enable, the IF/ID register (stall/flush), the ID/EX bubble insert and the FWDA/FWDB muxes.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rn  in  5  ReadRegister1 (post branch-link mux).
- id_rb  in  5  ReadRegister2 (post Reg2Loc mux).
- id_use_a, id_use_b  in  1 each  instruction actually reads rn / rb.
- id_rd  in  5  target register (post link mux; 30 for BL).
- id_reg_write, id_mem_read  in  1 each  control bits of the ID instruction.
- ex_br_taken  in  1  branch in EX resolved taken this cycle.
- fwd_a, fwd_b  out  2  operand select for the EX instruction: 00 regfile, 01 EX/MEM result, 10 MEM/WB write data.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  clear the IF/ID register.
- id_ex_bubble  out  1  load a NOP into ID/EX (RegWrite = memWrite = set_flags = 0).
- state  out  2  00 RUN, 01 LU_STALL, 10 FLUSH.

## Operation
- Scoreboard slots: S_EX, S_MEM and S_WB. Each slot holds {valid, rd, rn, rb, use_a, use_b, reg_write, mem_read}.
- Advance on each clk:
  - S_WB ← S_MEM.
  - S_MEM ← S_EX.
  - S_EX ← ID fields, or invalid when id_ex_bubble = 1.
- Eligible writer: valid & reg_write & rd ≠ 31. X31 is XZR and is never forwarded or stalled on.
- fwd_a:
  - 01 if S_MEM is an eligible writer and S_MEM.rd = S_EX.rn and S_EX.use_a.
  - Otherwise 10 if S_WB matches the same way.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- fwd_b: same rule against S_EX.rb and use_b.
- No WB→ID forwarding. The regfile writes on the falling edge, so ID reads see MEM/WB data.
- Load-use:
  - Condition: id_valid & S_EX eligible & S_EX.mem_read & ((id_use_a & id_rn = S_EX.rd) | (id_use_b & id_rb = S_EX.rd)).
  - Response: pc_stall = if_id_stall = id_ex_bubble = 1.
- Taken branch:
  - Condition: ex_br_taken = 1.
  - Response: if_id_flush = id_ex_bubble = 1, pc_stall = if_id_stall = 0.
- Simultaneous taken branch and load-use: the flush wins. The ID instruction is wrong-path, so no stall is raised.
- FSM (registered):
  - RUN → LU_STALL on load-use.
  - RUN → FLUSH on taken branch.
  - LU_STALL and FLUSH return to RUN after one cycle unless a new event occurs. Re-entry follows the same priority (FLUSH over LU_STALL).
  - The state output is informational. All control outputs are combinational from the current inputs and the scoreboard.

## Timing
- Reset (synchronous): all slots invalid, state = RUN.
  - Cycle after reset: fwd_a = fwd_b = 00; pc_stall, if_id_stall, if_id_flush, id_ex_bubble = 0.
- Control outputs are asserted in the same cycle the hazard is visible.
- Load-use costs exactly one bubble. In the next cycle the load is in S_MEM, the dependent instruction is re-presented in ID and the stall condition is clear. One cycle later the dependent instruction is in EX with fwd = 10.
- ALU-to-ALU back-to-back: zero penalty, fwd = 01.
- Taken-branch penalty: the two wrong-path instructions (IF and ID) are squashed. The flush signals are high for one cycle.
- rst asserted mid-stall or mid-flush: next cycle state = RUN and all outputs are deasserted. rst overrides every input.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds output ports stall_cnt (32 bits) and flush_cnt (32 bits).
  - stall_cnt increments on each cycle with a load-use stall; flush_cnt increments on each cycle with if_id_flush.
  - Both wrap at 2^32 and clear to 0 on rst.
- HAZARD_PERF_CNT_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- LDUR X1,[X2,#0] then ADD X3,X1,X4 → one cycle with pc_stall = if_id_stall = id_ex_bubble = 1, state = 01. Then the ADD in EX sees fwd_a = 10, fwd_b = 00.
- ADD X1,X2,X3 then SUB X4,X1,X1 → no stall; SUB in EX sees fwd_a = fwd_b = 01.
- ADD X1 then NOP then ADD X5,X6,X1 → fwd_b = 10. Both EX/MEM and MEM/WB writing X1 → fwd = 01 (priority).
- ADDS X31,X2,X3 followed by a reader of X31, including LDUR X31 then a reader of X31 → fwd = 00 and no stall.
- ex_br_taken = 1 in the same cycle as a load-use match in ID → if_id_flush = id_ex_bubble = 1, pc_stall = 0, state = 10. With HAZARD_PERF_CNT_EN: flush_cnt +1, stall_cnt unchanged.
- rst = 1 during LU_STALL → next cycle state = 00, all outputs 0, and a former S_MEM writer of X1 produces no forward.
